alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_pkg.sv | 25 ++
 rtl/alu_issue_fwd.sv | 31 +++
 rtl/alu_issue_stage.sv | 116 +++++++++++
 tb/tb_alu_issue_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: select codes, default widths, entry record.
package alu_issue_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_MUL  = 3'b011;
    localparam logic [2:0] ALU_DIV  = 3'b100;
    localparam logic [2:0] ALU_AND  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_SHL1 = 3'b111;

    typedef struct packed {
        logic [DW_DEF-1:0] op1;
        logic [DW_DEF-1:0] op2;
        logic [2:0]        sel;
        logic [RW_DEF-1:0] rs1;
        logic [RW_DEF-1:0] rs2;
        logic [RW_DEF-1:0] rd;
    } entry_t;

endpackage

// File: rtl/alu_issue_fwd.sv
// Per-entry operand bypass from the writeback bus (enabled by ALU_ISSUE_FORWARDING_EN).
module alu_issue_fwd
    import alu_issue_pkg::*;
(
    input  entry_t             entry_i,
    input  logic               wb_valid_i,
    input  logic [RW_DEF-1:0]  wb_rd_i,
    input  logic [DW_DEF-1:0]  wb_data_i,
    output entry_t             entry_o
);

`ifdef ALU_ISSUE_FORWARDING_EN
    logic hit1, hit2;

    // Register 0 is hard-wired, so a writeback to it never bypasses.
    assign hit1 = wb_valid_i && (wb_rd_i != '0) && (entry_i.rs1 == wb_rd_i);
    assign hit2 = wb_valid_i && (wb_rd_i != '0) && (entry_i.rs2 == wb_rd_i);

    always_comb begin
        entry_o = entry_i;
        if (hit1) entry_o.op1 = wb_data_i;
        if (hit2) entry_o.op2 = wb_data_i;
    end
`else
    logic unused_wb;

    assign unused_wb = ^{wb_valid_i, wb_rd_i, wb_data_i};
    assign entry_o   = entry_i;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry (main + skid) issue buffer feeding the ALU; forwarding via ALU_ISSUE_FORWARDING_EN.
// DW/RW must match the package widths (DW_DEF/RW_DEF) used by entry_t.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_op1,
    input  logic [DW-1:0] in_op2,
    input  logic [2:0]    in_sel,
    input  logic [RW-1:0] in_rs1,
    input  logic [RW-1:0] in_rs2,
    input  logic [RW-1:0] in_rd,
    input  logic          wb_valid,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_op1,
    output logic [DW-1:0] out_op2,
    output logic [2:0]    out_sel,
    output logic [RW-1:0] out_rd,
    output logic          out_dz
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0] state_q, state_d;
    logic       in_ready_q, in_ready_d;
    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    entry_t     in_ent, in_fwd, main_fwd, skid_fwd;
    logic       accept, xfer;

    assign in_ent = '{op1: in_op1, op2: in_op2, sel: in_sel,
                      rs1: in_rs1, rs2: in_rs2, rd: in_rd};

    alu_issue_fwd u_fwd_in (
        .entry_i(in_ent), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .entry_o(in_fwd)
    );

    alu_issue_fwd u_fwd_main (
        .entry_i(main_q), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .entry_o(main_fwd)
    );

    alu_issue_fwd u_fwd_skid (
        .entry_i(skid_q), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .entry_o(skid_fwd)
    );

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_fwd;
        skid_d  = skid_fwd;
        case (state_q)
            ST_EMPTY: if (accept) begin
                main_d  = in_fwd;
                state_d = ST_ONE;
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    main_d = in_fwd;
                end else if (accept) begin
                    skid_d  = in_fwd;
                    state_d = ST_FULL;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: if (xfer) begin
                main_d  = skid_fwd;
                state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over any accept or output transfer in the same cycle.
        if (flush) state_d = ST_EMPTY;
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign out_op1 = main_q.op1;
    assign out_op2 = main_q.op2;
    assign out_sel = main_q.sel;
    assign out_rd  = main_q.rd;
    assign out_dz  = out_valid && (main_q.sel == ALU_DIV) && (main_q.op2 == '0);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; forwarding expectations follow ALU_ISSUE_FORWARDING_EN.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_op1, in_op2;
    logic [2:0]  in_sel;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_op1, out_op2;
    logic [2:0]  out_sel;
    logic [4:0]  out_rd;
    logic        out_dz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_sel(in_sel),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_sel(out_sel),
        .out_rd(out_rd), .out_dz(out_dz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] s, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] d);
        in_valid = v; in_op1 = a; in_op2 = b; in_sel = s;
        in_rs1 = r1; in_rs2 = r2; in_rd = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        drive(1'b0, 0, 0, 3'd0, 0, 0, 0);
        step(); step();
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_in_ready",  {31'd0, in_ready}, 1);
        check("rst_out_dz",    {31'd0, out_dz}, 0);
        check("rst_out_op1",   out_op1, 0);
        check("rst_out_op2",   out_op2, 0);
        check("rst_out_sel",   {29'd0, out_sel}, 0);
        check("rst_out_rd",    {27'd0, out_rd}, 0);
        rst = 1'b0;
        step();

        // Basic add: one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 5, 3, 3'b000, 1, 2, 7);
        step();
        drive(1'b0, 0, 0, 3'd0, 0, 0, 0);
        check("add_valid", {31'd0, out_valid}, 1);
        check("add_op1", out_op1, 5);
        check("add_op2", out_op2, 3);
        check("add_rd", {27'd0, out_rd}, 7);
        check("add_result", out_op1 + out_op2, 8);
        step();
        check("add_drained", {31'd0, out_valid}, 0);

        // Backpressure with A, B, C
        out_ready = 1'b0;
        drive(1'b1, 10, 0, 3'b101, 0, 0, 1);
        step();
        check("A_ready", {31'd0, in_ready}, 1);
        drive(1'b1, 20, 0, 3'b110, 0, 0, 2);
        step();
        check("full_in_ready", {31'd0, in_ready}, 0);
        check("full_head_op1", out_op1, 10);
        drive(1'b1, 30, 0, 3'b111, 0, 0, 3);
        step();
        check("hold_in_ready", {31'd0, in_ready}, 0);
        check("hold_head_op1", out_op1, 10);
        check("hold_head_sel", {29'd0, out_sel}, 32'b101);
        out_ready = 1'b1;
        step();
        check("B_head_rd", {27'd0, out_rd}, 2);
        check("B_head_op1", out_op1, 20);
        check("C_ready", {31'd0, in_ready}, 1);
        step();
        drive(1'b0, 0, 0, 3'd0, 0, 0, 0);
        check("C_head_rd", {27'd0, out_rd}, 3);
        check("C_head_op1", out_op1, 30);
        step();
        check("C_drained", {31'd0, out_valid}, 0);

        // Forwarding to an incoming op1
        out_ready = 1'b0;
        drive(1'b1, 0, 0, 3'b000, 4, 0, 9);
        wb_valid = 1'b1; wb_rd = 4; wb_data = 32'h1234;
        step();
        drive(1'b0, 0, 0, 3'd0, 0, 0, 0);
        wb_valid = 1'b0;
        check("fwd_rs1", out_op1, FWD ? 32'h1234 : 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        drive(1'b1, 0, 0, 3'b000, 0, 0, 9);
        wb_valid = 1'b1; wb_rd = 0; wb_data = 32'h1234;
        step();
        drive(1'b0, 0, 0, 3'd0, 0, 0, 0);
        wb_valid = 1'b0;
        check("fwd_r0_blocked", out_op1, 0);
        out_ready = 1'b1;
        step();
        check("fwd_drained", {31'd0, out_valid}, 0);

        // Divide-by-zero flag and forwarding into a held head
        out_ready = 1'b0;
        drive(1'b1, 100, 0, 3'b100, 0, 6, 5);
        step();
        drive(1'b0, 0, 0, 3'd0, 0, 0, 0);
        check("dz_set", {31'd0, out_dz}, 1);
        wb_valid = 1'b1; wb_rd = 6; wb_data = 7;
        step();
        wb_valid = 1'b0;
        check("dz_after_fwd", {31'd0, out_dz}, FWD ? 32'd0 : 32'd1);
        check("dz_op2_after_fwd", out_op2, FWD ? 32'd7 : 32'd0);

        // FULL then flush with simultaneous in_valid and out_ready
        drive(1'b1, 55, 1, 3'b001, 0, 0, 4);
        step();
        check("pre_flush_full", {31'd0, in_ready}, 0);
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 0, 0, 3'd0, 0, 0, 0);
        check("flush_valid", {31'd0, out_valid}, 0);
        check("flush_in_ready", {31'd0, in_ready}, 1);
        check("flush_dz", {31'd0, out_dz}, 0);
        step();
        check("flush_retained", {31'd0, out_valid}, 0);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        drive(1'b1, 1, 1, 3'b000, 0, 0, 1);
        step();
        drive(1'b1, 2, 2, 3'b000, 0, 0, 2);
        step();
        drive(1'b0, 0, 0, 3'd0, 0, 0, 0);
        check("arst_pre_full", {31'd0, in_ready}, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 0);
        check("arst_in_ready", {31'd0, in_ready}, 1);
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("arst_stays_empty", {31'd0, out_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
